byte_port_sched: RTL and testbench

Timed byte-output scheduler that sits directly upstream of the byte-to-bits splitter and drives its 8-bit input.
- Accepts (timestamp, data, mask) commands over a valid/ready port and buffers them in a small FIFO.
- Applies each command to a registered output byte when a free-running time counter reaches the command's timestamp.
- The splitter fans that byte out to 8 single-bit outputs.

---
 rtl/byte_port_pkg.sv | 26 ++
 rtl/byte_port_fifo.sv | 52 +++++
 rtl/byte_port_sched.sv | 103 ++++++++++
 tb/tb_byte_port_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_port_pkg.sv
// Shared types and constants for the timed byte-output scheduler.
package byte_port_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DEFAULT_TW = 32;

    typedef struct packed {
        logic [DEFAULT_TW-1:0] tstamp;
        logic [BYTE_W-1:0]     data;
        logic [BYTE_W-1:0]     mask;
    } cmd_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [BYTE_W-1:0] merge_byte(
        input logic [BYTE_W-1:0] old_val,
        input logic [BYTE_W-1:0] new_val,
        input logic [BYTE_W-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/byte_port_fifo.sv
// Synchronous command FIFO with first-word head view; full/empty/count decoded from occupancy.
module byte_port_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/byte_port_sched.sv
// Timed byte-output scheduler: applies masked byte commands when the time counter hits their stamp.
// Optional BYTE_PORT_LATE_CNT_EN adds a saturating late-discard counter output late_cnt.
module byte_port_sched
    import byte_port_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TW         = DEFAULT_TW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [TW-1:0]     din_time,
    input  logic [7:0]        din_data,
    input  logic [7:0]        din_mask,
    output logic [7:0]        dout,
    output logic [TW-1:0]     time_now,
    output logic              running,
    output logic              empty,
`ifdef BYTE_PORT_LATE_CNT_EN
    output logic [15:0]       late_cnt,
`endif
    output logic              late_pulse
);

    localparam int unsigned CW = TW + 2 * BYTE_W;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     head;
    logic [TW-1:0]     head_time;
    logic [BYTE_W-1:0] head_data;
    logic [BYTE_W-1:0] head_mask;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              head_valid;
    logic              apply_pop;
    logic              late_pop;
    logic              pop;

    byte_port_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_valid),
        .wdata ({din_time, din_data, din_mask}),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_time  = head[CW-1 -: TW];
    assign head_data  = head[2*BYTE_W-1 -: BYTE_W];
    assign head_mask  = head[BYTE_W-1:0];
    assign head_valid = (fifo_count != '0);
    assign din_ready  = !fifo_full;
    assign empty      = fifo_empty;

    // Next state and head evaluation; pops compare against the pre-reload time.
    always_comb begin
        state_d   = state_q;
        apply_pop = 1'b0;
        late_pop  = 1'b0;
        if (state_q == IDLE && start) state_d = RUN;
        if (state_q == RUN && head_valid) begin
            apply_pop = (head_time == time_now);
            late_pop  = (head_time <  time_now);
        end
        pop = apply_pop || late_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            running    <= 1'b0;
            time_now   <= '0;
            dout       <= '0;
            late_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            running    <= (state_d == RUN);
            late_pulse <= late_pop;
            if (state_q == RUN && !start) time_now <= time_now + TW'(1);
            else                          time_now <= '0;
            if (apply_pop) dout <= merge_byte(dout, head_data, head_mask);
        end
    end

`ifdef BYTE_PORT_LATE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start)                      late_cnt <= '0;
        else if (late_pop && late_cnt != '1)   late_cnt <= late_cnt + 16'(1);
    end
`endif

endmodule

// File: tb/tb_byte_port_sched.sv
// Directed self-checking bench for byte_port_sched (default FIFO_DEPTH=8, TW=32).
module tb_byte_port_sched;
    import byte_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_time;
    logic [7:0]  din_data;
    logic [7:0]  din_mask;
    logic [7:0]  dout;
    logic [31:0] time_now;
    logic        running;
    logic        empty;
    logic        late_pulse;
`ifdef BYTE_PORT_LATE_CNT_EN
    logic [15:0] late_cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    byte_port_sched #(.FIFO_DEPTH(8), .TW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_time   (din_time),
        .din_data   (din_data),
        .din_mask   (din_mask),
        .dout       (dout),
        .time_now   (time_now),
        .running    (running),
        .empty      (empty),
`ifdef BYTE_PORT_LATE_CNT_EN
        .late_cnt   (late_cnt),
`endif
        .late_pulse (late_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; din_valid = 1'b0;
        din_time = '0; din_data = '0; din_mask = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_cmd(input logic [31:0] t, input logic [7:0] d, input logic [7:0] m);
        int n;
        n = 0;
        din_valid = 1'b1; din_time = t; din_data = d; din_mask = m;
        while (!din_ready && n < 100) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (din_ready !== 1'b1) $display("FAIL push_ready got=%b want=1", din_ready);
        else pass_cnt++;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_time(input logic [31:0] t);
        int n;
        n = 0;
        while (time_now !== t && n < 500) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (time_now !== t) $display("FAIL wait_time got=%0d want=%0d", time_now, t);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if ({dout, time_now, running, empty, din_ready, late_pulse} !== {8'h00, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_state got dout=%h t=%0d run=%b emp=%b rdy=%b late=%b", dout, time_now, running, empty, din_ready, late_pulse);
        else pass_cnt++;
        push_cmd(32'd1, 8'hFF, 8'hFF);
        push_cmd(32'd30, 8'h12, 8'hFF);
        push_cmd(32'd31, 8'h34, 8'hFF);
        pulse_start();
        wait_time(32'd3);
        chk_cnt++;
        if (dout !== 8'hFF) $display("FAIL reset_pre_apply got=%h want=ff", dout);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++;
        if ({dout, time_now, running, empty, din_ready, late_pulse} !== {8'h00, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("FAIL reset_midrun got dout=%h t=%0d run=%b emp=%b rdy=%b late=%b", dout, time_now, running, empty, din_ready, late_pulse);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (time_now !== 32'd0) $display("FAIL idle_time_held got=%0d want=0", time_now);
        else pass_cnt++;
        pulse_start();
        wait_time(32'd35);
        chk_cnt++;
        if (dout !== 8'h00 || empty !== 1'b1) $display("FAIL reset_aborts got dout=%h emp=%b want 00/1", dout, empty);
        else pass_cnt++;
    endtask

    task automatic test_basic_apply();
        do_reset();
        push_cmd(32'd5, 8'hA5, 8'hFF);
        pulse_start();
        chk_cnt++;
        if (time_now !== 32'd0 || running !== 1'b1) $display("FAIL start_time got t=%0d run=%b want 0/1", time_now, running);
        else pass_cnt++;
        wait_time(32'd5);
        chk_cnt++;
        if (dout !== 8'h00) $display("FAIL basic_before got=%h want=00", dout);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (time_now !== 32'd6 || dout !== 8'hA5) $display("FAIL basic_apply got t=%0d dout=%h want 6/a5", time_now, dout);
        else pass_cnt++;
    endtask

    task automatic test_masking();
        do_reset();
        push_cmd(32'd3, 8'hF0, 8'hFF);
        push_cmd(32'd10, 8'h0F, 8'h3C);
        pulse_start();
        wait_time(32'd4);
        chk_cnt++;
        if (dout !== 8'hF0) $display("FAIL mask_first got=%h want=f0", dout);
        else pass_cnt++;
        wait_time(32'd11);
        chk_cnt++;
        if (dout !== 8'hCC) $display("FAIL mask_merge got=%h want=cc", dout);
        else pass_cnt++;
    endtask

    task automatic test_late();
        do_reset();
        push_cmd(32'd2, 8'h5A, 8'hFF);
        pulse_start();
        wait_time(32'd20);
        push_cmd(32'd15, 8'hFF, 8'hFF);
        chk_cnt++;
        if (late_pulse !== 1'b0 || time_now !== 32'd21) $display("FAIL late_early got late=%b t=%0d want 0/21", late_pulse, time_now);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (late_pulse !== 1'b1 || dout !== 8'h5A || empty !== 1'b1) $display("FAIL late_pulse got late=%b dout=%h emp=%b want 1/5a/1", late_pulse, dout, empty);
        else pass_cnt++;
`ifdef BYTE_PORT_LATE_CNT_EN
        chk_cnt++;
        if (late_cnt !== 16'd1) $display("FAIL late_cnt got=%0d want=1", late_cnt);
        else pass_cnt++;
`endif
        tick();
        chk_cnt++;
        if (late_pulse !== 1'b0) $display("FAIL late_one_cycle got=%b want=0", late_pulse);
        else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 8; i++) push_cmd(32'(i), 8'(i), 8'hFF);
        chk_cnt++;
        if (din_ready !== 1'b0 || empty !== 1'b0) $display("FAIL full_ready got rdy=%b emp=%b want 0/0", din_ready, empty);
        else pass_cnt++;
        din_valid = 1'b1; din_time = 32'd50; din_data = 8'h77; din_mask = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        din_valid = 1'b0;
        chk_cnt++;
        if (din_ready !== 1'b0) $display("FAIL full_hold got rdy=%b want=0", din_ready);
        else pass_cnt++;
        pulse_start();
        tick();
        chk_cnt++;
        if (din_ready !== 1'b0 || time_now !== 32'd1) $display("FAIL full_before_pop got rdy=%b t=%0d want 0/1", din_ready, time_now);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (din_ready !== 1'b1 || dout !== 8'h01) $display("FAIL full_reraise got rdy=%b dout=%h want 1/01", din_ready, dout);
        else pass_cnt++;
        wait_time(32'd10);
        chk_cnt++;
        if (dout !== 8'h08 || empty !== 1'b1) $display("FAIL full_drain got dout=%h emp=%b want 08/1", dout, empty);
        else pass_cnt++;
    endtask

    task automatic test_order();
        do_reset();
        pulse_start();
        push_cmd(32'd30, 8'h3C, 8'hFF);
        push_cmd(32'd25, 8'hFF, 8'hFF);
        wait_time(32'd26);
        chk_cnt++;
        if (dout !== 8'h00) $display("FAIL order_blocked got=%h want=00", dout);
        else pass_cnt++;
        wait_time(32'd31);
        chk_cnt++;
        if (dout !== 8'h3C || empty !== 1'b0 || late_pulse !== 1'b0) $display("FAIL order_first got dout=%h emp=%b late=%b want 3c/0/0", dout, empty, late_pulse);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dout !== 8'h3C || empty !== 1'b1 || late_pulse !== 1'b1) $display("FAIL order_second got dout=%h emp=%b late=%b want 3c/1/1", dout, empty, late_pulse);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        do_reset();
        pulse_start();
        wait_time(32'd12);
        din_valid = 1'b1; din_time = 32'd8; din_data = 8'hC3; din_mask = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0;
        chk_cnt++;
        if (time_now !== 32'd0 || empty !== 1'b0 || running !== 1'b1) $display("FAIL restart_reload got t=%0d emp=%b run=%b want 0/0/1", time_now, empty, running);
        else pass_cnt++;
        wait_time(32'd8);
        chk_cnt++;
        if (dout !== 8'h00) $display("FAIL restart_before got=%h want=00", dout);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dout !== 8'hC3 || late_pulse !== 1'b0) $display("FAIL restart_apply got dout=%h late=%b want c3/0", dout, late_pulse);
        else pass_cnt++;
        push_cmd(32'd15, 8'h99, 8'h0F);
        wait_time(32'd15);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cnt++;
        if (dout !== 8'hC9 || time_now !== 32'd0 || empty !== 1'b1) $display("FAIL start_due_pop got dout=%h t=%0d emp=%b want c9/0/1", dout, time_now, empty);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_apply();
        test_masking();
        test_late();
        test_full();
        test_order();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
